// File: rtl/vpi_step_counter.sv
// vpi_step_counter: parametrised up/down step counter with synchronous load,
// wrap or saturate overflow handling, a terminal-count pulse, and a
// single-entry newest-wins sample port for the VPI monitor task.
module vpi_step_counter #(
  parameter int WIDTH    = 12,
  parameter int STEP     = 1,
  parameter int SATURATE = 0,
  parameter int INIT     = 0,
  parameter int DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [WIDTH-1:0]  smp_data,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_X = WIDTH'(INIT);

  logic [WIDTH-1:0]  count_q, count_d;
  logic              tc_q, tc_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [WIDTH:0]    sum, diff;
  logic              step_ovf;
  logic [WIDTH-1:0]  step_val;
  logic              new_smp;

  // Step arithmetic: one extra bit exposes carry (up) or borrow (down).
  always_comb begin
    sum      = {1'b0, count_q} + STEP_X;
    diff     = {1'b0, count_q} - STEP_X;
    step_ovf = up ? sum[WIDTH] : diff[WIDTH];
    step_val = up ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
    // Clamp to the limit in the overflow direction; tc then marks the clamp.
    if (SATURATE != 0 && step_ovf)
      step_val = up ? '1 : '0;
  end

  // Next-state: load beats step beats hold; sample slot is newest-wins.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    new_smp = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    if (load) begin
      count_d = load_val;
      new_smp = 1'b1;                    // load always publishes, even if unchanged
    end else if (en) begin
      count_d = step_val;
      tc_d    = step_ovf;
      new_smp = (step_val != count_q);   // pinned-at-limit steps publish nothing
    end
    if (new_smp) begin
      data_d  = count_d;
      valid_d = 1'b1;
      // Overwriting an unconsumed sample is a drop; counter sticks at max.
      if (valid_q && !smp_ready && drop_q != '1)
        drop_d = drop_q + 1'b1;
    end else if (valid_q && smp_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= INIT_X;
      tc_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign smp_valid = valid_q;
  assign smp_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_vpi_step_counter.sv
// Directed bench for vpi_step_counter: three instances cover wrap (12-bit
// and 4-bit/step-3 with narrow drop counter) and saturate (INIT=5).
module tb_vpi_step_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: WIDTH=12, STEP=1, wrap
  logic        a_en, a_up, a_load, a_rdy, a_tc, a_vld;
  logic [11:0] a_lv, a_cnt, a_dat;
  logic [7:0]  a_drop;
  vpi_step_counter #(.WIDTH(12), .STEP(1), .SATURATE(0), .INIT(0), .DROP_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
    .count(a_cnt), .tc(a_tc), .smp_valid(a_vld), .smp_ready(a_rdy),
    .smp_data(a_dat), .drop_cnt(a_drop));

  // Instance B: WIDTH=4, STEP=3, wrap, DROP_W=2
  logic       b_en, b_up, b_load, b_rdy, b_tc, b_vld;
  logic [3:0] b_lv, b_cnt, b_dat;
  logic [1:0] b_drop;
  vpi_step_counter #(.WIDTH(4), .STEP(3), .SATURATE(0), .INIT(0), .DROP_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .count(b_cnt), .tc(b_tc), .smp_valid(b_vld), .smp_ready(b_rdy),
    .smp_data(b_dat), .drop_cnt(b_drop));

  // Instance C: WIDTH=12, STEP=1, saturate, INIT=5
  logic        c_en, c_up, c_load, c_rdy, c_tc, c_vld;
  logic [11:0] c_lv, c_cnt, c_dat;
  logic [7:0]  c_drop;
  vpi_step_counter #(.WIDTH(12), .STEP(1), .SATURATE(1), .INIT(5), .DROP_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv),
    .count(c_cnt), .tc(c_tc), .smp_valid(c_vld), .smp_ready(c_rdy),
    .smp_data(c_dat), .drop_cnt(c_drop));

  initial begin
    int bad, tcs, acc, nsmp;
    logic [11:0] exp_c [3];
    logic        exp_t [3];

    rst_n = 1'b0;
    a_en = 0; a_up = 0; a_load = 0; a_rdy = 0; a_lv = '0;
    b_en = 0; b_up = 0; b_load = 0; b_rdy = 0; b_lv = '0;
    c_en = 0; c_up = 0; c_load = 0; c_rdy = 0; c_lv = '0;
    tick(); tick();
    chk("a_rst_cnt", a_cnt, 0);
    chk("a_rst_tc", a_tc, 0);
    chk("a_rst_vld", a_vld, 0);
    chk("a_rst_dat", a_dat, 0);
    chk("a_rst_drop", a_drop, 0);
    chk("c_rst_cnt", c_cnt, 5);
    rst_n = 1'b1;

    // A: full wrap run, consumer always ready
    a_en = 1; a_up = 1; a_rdy = 1;
    bad = 0; tcs = 0; acc = 0;
    for (int i = 1; i <= 4096; i++) begin
      tick();
      if (a_cnt !== 12'(i % 4096)) bad++;
      if (a_vld !== 1'b1 || a_dat !== a_cnt) bad++;
      if (a_tc === 1'b1) begin
        tcs++;
        if (a_cnt !== 12'd0) bad++;
      end
      if (a_vld === 1'b1) acc++;
    end
    a_en = 0;
    tick();
    chk("a_run_bad", bad, 0);
    chk("a_run_tcs", tcs, 1);
    chk("a_run_acc", acc, 4096);
    chk("a_run_drop", a_drop, 0);
    chk("a_hold_vld", a_vld, 0);
    chk("a_hold_cnt", a_cnt, 0);
    chk("a_hold_tc", a_tc, 0);

    // A: stalled consumer, 5 up steps
    a_rdy = 0; a_en = 1;
    repeat (5) tick();
    chk("a_stall_cnt", a_cnt, 5);
    chk("a_stall_vld", a_vld, 1);
    chk("a_stall_dat", a_dat, 5);
    chk("a_stall_drop", a_drop, 4);
    a_en = 0;
    tick();
    chk("a_stall_hold_vld", a_vld, 1);
    chk("a_stall_hold_dat", a_dat, 5);
    a_rdy = 1;
    tick();
    chk("a_xfer_vld", a_vld, 0);
    chk("a_xfer_dat", a_dat, 5);
    chk("a_xfer_drop", a_drop, 4);

    // A: load of an unchanged value still publishes a sample
    a_load = 1; a_lv = 12'd5;
    tick();
    a_load = 0;
    chk("a_ld_same_cnt", a_cnt, 5);
    chk("a_ld_same_vld", a_vld, 1);
    chk("a_ld_same_tc", a_tc, 0);

    // B: step-3 down from 0 wraps to 13 with tc, then 10 without
    b_rdy = 1; b_en = 1; b_up = 0;
    tick();
    chk("b_dn1_cnt", b_cnt, 13);
    chk("b_dn1_tc", b_tc, 1);
    tick();
    chk("b_dn2_cnt", b_cnt, 10);
    chk("b_dn2_tc", b_tc, 0);
    b_rdy = 0; b_up = 1;
    repeat (10) tick();
    chk("b_sat_drop", b_drop, 3);
    chk("b_up10_cnt", b_cnt, 8);
    b_load = 1; b_lv = 4'd7;
    tick();
    b_load = 0; b_en = 0;
    chk("b_ld_en_cnt", b_cnt, 7);
    chk("b_ld_en_tc", b_tc, 0);
    chk("b_ld_en_dat", b_dat, 7);
    chk("b_ld_en_drop", b_drop, 3);

    // C: saturate at the top
    c_rdy = 1; c_load = 1; c_lv = 12'd4094;
    tick();
    c_load = 0;
    nsmp = (c_vld === 1'b1) ? 1 : 0;
    chk("c_ld_cnt", c_cnt, 4094);
    c_en = 1; c_up = 1;
    exp_c[0] = 12'd4095; exp_c[1] = 12'd4095; exp_c[2] = 12'd4095;
    exp_t[0] = 1'b0;     exp_t[1] = 1'b1;     exp_t[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("c_up%0d_cnt", i), c_cnt, exp_c[i]);
      chk($sformatf("c_up%0d_tc", i), c_tc, exp_t[i]);
      if (c_vld === 1'b1) nsmp++;
    end
    chk("c_up_nsmp", nsmp, 2);

    // C: saturate at the bottom; exact reach is not a clamp
    c_en = 0; c_load = 1; c_lv = 12'd1;
    tick();
    c_load = 0; c_en = 1; c_up = 0;
    tick();
    chk("c_dn1_cnt", c_cnt, 0);
    chk("c_dn1_tc", c_tc, 0);
    tick();
    chk("c_dn2_cnt", c_cnt, 0);
    chk("c_dn2_tc", c_tc, 1);
    c_en = 0;
    tick();
    chk("c_hold_tc", c_tc, 0);
    chk("c_hold_vld", c_vld, 0);

    // C: pending sample with two drops, ending on a clamped step
    c_rdy = 0; c_load = 1; c_lv = 12'd4093;
    tick();
    c_load = 0; c_en = 1; c_up = 1;
    repeat (3) tick();
    c_en = 0;
    chk("c_pend_cnt", c_cnt, 4095);
    chk("c_pend_tc", c_tc, 1);
    chk("c_pend_drop", c_drop, 2);
    chk("c_pend_vld", c_vld, 1);

    // Reset mid-operation
    rst_n = 1'b0;
    tick();
    chk("c_mrst_cnt", c_cnt, 5);
    chk("c_mrst_vld", c_vld, 0);
    chk("c_mrst_drop", c_drop, 0);
    chk("c_mrst_tc", c_tc, 0);
    chk("c_mrst_dat", c_dat, 0);
    chk("a_mrst_cnt", a_cnt, 0);
    chk("a_mrst_drop", a_drop, 0);
    chk("b_mrst_drop", b_drop, 0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vpi_step_counter.md
# vpi_step_counter

Parametrised successor to the team's free-running VPI clock counter. It keeps the plain increment-per-clock behaviour and generalises it in width, step size, direction and overflow mode, with synchronous load. Each new count value is offered on a valid/ready sample port for the VPI monitor task, so the testbench no longer has to sample inside the counter's always block. It sits between the simulation clock generator and the VPI sampling harness.

## Interface
- WIDTH, 12: counter width in bits, ≥ 2.
- STEP, 1: increment/decrement magnitude, 1 ≤ STEP ≤ 2^WIDTH−1.
- SATURATE, 0: 0 = modulo wrap, 1 = clamp at 0 / 2^WIDTH−1.
- INIT, 0: count value after reset, < 2^WIDTH.
- DROP_W, 8: width of dropped-sample counter.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  step enable.
- up  in  1  1 = count up, 0 = count down; sampled only when a step occurs.
- load  in  1  synchronous load; priority over en.
- load_val  in  WIDTH  value written on load.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- smp_valid  out  1  sample available.
- smp_ready  in  1  consumer accepts sample.
- smp_data  out  WIDTH  sampled count value.
- drop_cnt  out  DROP_W  samples overwritten before acceptance; saturates.

## Operation
- Per-edge priority: rst_n low > load > en > hold.
- Load: count ← load_val; tc ← 0; a sample is always issued, even if the value is unchanged.
- Step (en=1, load=0): the next value is computed in WIDTH+1 bits.
  - Up: count + STEP.
  - Down: count − STEP.
  - SATURATE=0: result taken modulo 2^WIDTH; tc ← 1 iff carry (up) or borrow (down) occurred.
  - SATURATE=1: result clamped to 2^WIDTH−1 (up) or 0 (down); tc ← 1 iff the clamp was applied, including repeated steps while pinned at the limit.
  - Exactly reaching a limit without exceeding it is not a clamp: tc=0.
  - A sample is issued only if the new value differs from the old one.
- Hold (en=0, load=0): count unchanged; tc ← 0; no sample.
- Sample register (single entry, newest wins); the conditions below are evaluated at each edge:
  - New sample, slot empty or (smp_valid & smp_ready): smp_data ← new count; smp_valid ← 1; no drop.
  - New sample, smp_valid=1 and smp_ready=0: smp_data overwritten; drop_cnt increments (saturating at 2^DROP_W−1).
  - No new sample and smp_valid & smp_ready: smp_valid ← 0; smp_data holds its last value.
- smp_data and smp_valid must not change while smp_valid=1 and smp_ready=0, unless a new sample arrives (overwrite case).

## Timing
- Reset values: count=INIT, tc=0, smp_valid=0, smp_data=0, drop_cnt=0.
- Reset mid-operation: a pending sample is discarded and is not counted as a drop. Outputs show reset values in the cycle after the rst_n-low edge.
- Latency: count, tc, smp_data and smp_valid all update on the same edge as the triggering load or step. smp_data equals count in the cycle the sample first appears.
- tc is high for one cycle per triggering step. It stays high across consecutive cycles only for consecutive wrapping or clamped steps.
- Handshake: a transfer occurs on an edge where smp_valid & smp_ready are both 1. smp_ready may be high while smp_valid is low, with no effect.
- Simultaneous load and en: load wins; up is ignored.
- No combinational path from any input to any output.

## Test plan
- WIDTH=12, STEP=1, wrap, en=up=1 for 4096 cycles, smp_ready=1:
  - count runs 1…4095, then 0.
  - tc is high only in the cycle count=0.
  - 4096 samples are accepted; drop_cnt=0.
- WIDTH=4, STEP=3, wrap, count=0, up=0, one step -> count=13, tc=1. Next step -> count=10, tc=0.
- SATURATE=1, WIDTH=12, load 4094, then en=up=1 for 3 cycles:
  - count = 4095, 4095, 4095.
  - tc = 0, 1, 1.
  - Exactly 2 samples total (load, then 4095).
- smp_ready=0, count=0, 5 up steps:
  - smp_valid=1, smp_data=5, drop_cnt=4.
  - Then ready=1, en=0: one transfer, and smp_valid=0 on the following cycle.
- DROP_W=2, smp_ready=0, 10 steps -> drop_cnt saturates at 3. load and en together with load_val=7 -> count=7, tc=0.
- Pending sample with drop_cnt=2, then rst_n low one cycle -> count=INIT, smp_valid=0, drop_cnt=0, tc=0 on the next cycle.
